csr_timer_bank: RTL and testbench
=================================

# csr_timer_bank

Parametrised bank of LoongArch-style CSR timers for the CPU core's CSR unit, generalising the single TCFG/TVAL/TICLR timer to `N_TIMER` independent channels with a shared free-running stable counter. Each channel has one-shot or periodic mode and a sticky interrupt pending bit. Channels can be frozen by a debug-halt input. The block decodes its own CSR address window and returns read data combinationally. The main CSR file ORs `csr_rvalue` into its read mux and routes `timer_int` into ESTAT.IS.

## Interface
- `N_TIMER`, 2: number of timer channels, 1..8.
- `TIMER_BASE`, 14'h41: CSR number of channel 0 TCFG.
- `CH_STRIDE`, 8: CSR-number spacing between channels.
- `SCNT_W`, 64: stable counter width, 32..64.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `csr_num`  in  14  CSR number for the read and write access.
- `csr_we`  in  1  write strobe, one cycle per write.
- `csr_wmask`  in  32  per-bit write enable.
- `csr_wvalue`  in  32  write data.
- `csr_hit`  out  1  `csr_num` selects a register in this bank (combinational).
- `csr_rvalue`  out  32  read data (combinational); 0 when `csr_hit`=0.
- `dbg_halt`  in  1  freezes all channel counters while high.
- `timer_int`  out  N_TIMER  per-channel sticky interrupt pending.
- `stable_counter`  out  SCNT_W  free-running counter value.

## Operation
- Address map for channel i, with b = TIMER_BASE + i*CH_STRIDE:
  - TCFG at b.
  - TVAL at b+1, read-only.
  - TICLR at b+3, write-1-to-clear, reads 0.
  - Every other number in the window misses (`csr_hit`=0).
- TCFG fields: {initval[29:0], periodic, en}.
  - Masked write: new = wmask&wvalue | ~wmask&old.
  - A TCFG write whose *new* en=1 loads cnt <= {new initval, 2'b00}, taking priority over counting that cycle.
  - A write with new en=0 freezes cnt at its current value.
- Counter cnt[31:0] per channel; TVAL reads cnt. Idle value is 32'hFFFF_FFFF. On each edge, with en=1, cnt≠idle and dbg_halt=0:
  - cnt==0 and periodic=1: cnt <= {initval,2'b00}.
  - cnt==0 and periodic=0: cnt <= idle. The counter does not wrap into decrementing from idle.
  - otherwise: cnt <= cnt-1.
- Pending bit: `timer_int[i]` is set on the edge where en=1, dbg_halt=0 and cnt==0.
  - It is cleared by a TICLR write with wmask[0]&wvalue[0]=1.
  - If set and clear fall on the same edge, set wins.
  - Writing 0 to TICLR, or writing any TVAL bit, has no effect.
- initval=0 with periodic=1: cnt stays 0 and pending is re-set on every enabled edge.
- Stable counter: increments by 1 on every edge and wraps modulo 2^SCNT_W. It is unaffected by dbg_halt.
- Reset values:
  - cnt = idle.
  - en = periodic = 0; initval = 0.
  - timer_int = 0.
  - stable_counter = 0.
  - csr_rvalue and csr_hit follow csr_num combinationally.
- Reset asserted mid-count forces every register to its reset value immediately (asynchronously). Counting restarts only after a new TCFG write.

## Timing
- TCFG write at edge t: TVAL reads {initval,00} after t; the first decrement happens at t+1.
- One-shot with initval=1, written at t:
  - cnt is 4 after t, 3/2/1/0 after t+1..t+4.
  - timer_int rises after t+5, when cnt also returns to idle.
- The TICLR clear is visible in the cycle after the write edge.
- Read path has zero latency. Write-then-read of the same register sees the new value on the next cycle.
- dbg_halt high at an edge: cnt and pending-set are both suppressed at that edge. Register writes still take effect.

## Structure
- Package `csr_timer_pkg`: TCFG field offsets, register offsets (TCFG=0, TVAL=1, TICLR=3), idle constant 32'hFFFF_FFFF, and the `tcfg_t` field struct.
- Sub-module `csr_timer_chan`: one channel holding TCFG, cnt and pending. Generated N_TIMER times.
- The top level holds address decode, the read mux and the stable counter.

## Test plan
- Reset: release resetn → all TVAL read 32'hFFFF_FFFF, timer_int=0, stable_counter counts 0,1,2…
- One-shot: write ch0 TCFG=32'h0000_0005 (initval=1, en=1) → TVAL sequence 4,3,2,1,0, then idle; timer_int[0] rises exactly 5 cycles after the write edge and stays high; TVAL remains idle.
- Periodic: write ch1 TCFG=0x0B (initval=2, periodic=1, en=1) → TVAL goes 8…0, then reloads to 8; timer_int[1] set. A TICLR write of 1 clears it for the next 8 cycles, then it re-sets.
- Clear/set collision: issue the TICLR write on the same edge that cnt==0 → timer_int stays 1.
- Halt and masking: assert dbg_halt for 3 cycles mid-count → TVAL holds and stable_counter advances by 3. A TCFG write with wmask=0x1 and wvalue=0 → en=0, initval unchanged, TVAL frozen.
- Decode: read TIMER_BASE+2 and a TICLR address → csr_hit is 0 and 1 respectively, and csr_rvalue=0 in both cases. Assert resetn low mid-count → TVAL reads idle at once.

Source files
------------

// File: rtl/csr_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_pkg
// Description : Shared definitions for the CSR timer bank: TCFG field
//               offsets, per-channel register offsets inside the CSR
//               window, the idle counter value and the TCFG field struct.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_timer_pkg;

    // TCFG field layout: {initval[29:0], periodic, en}
    localparam int TCFG_EN_BIT       = 0;
    localparam int TCFG_PERIODIC_BIT = 1;
    localparam int TCFG_INITVAL_LSB  = 2;
    localparam int TCFG_INITVAL_W    = 30;

    // Register offsets relative to a channel's base CSR number
    localparam logic [13:0] REG_OFF_TCFG  = 14'd0;
    localparam logic [13:0] REG_OFF_TVAL  = 14'd1;
    localparam logic [13:0] REG_OFF_TICLR = 14'd3;

    // Bit of a TICLR write that requests a pending clear
    localparam int TICLR_CLR_BIT = 0;

    // Counter value of a channel that is not counting
    localparam logic [31:0] CNT_IDLE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [29:0] initval;
        logic        periodic;
        logic        en;
    } tcfg_t;

    // Counter start value: initval scaled by 4
    function automatic logic [31:0] reload_value(input tcfg_t cfg);
        return {cfg.initval, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_timer_chan.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_chan
// Description : One timer channel: TCFG register, down counter and sticky
//               interrupt pending bit.
// Ports       : clk, resetn       - clock, async active-low reset
//               tcfg_we, ticlr_we - decoded write strobes for this channel
//               wmask, wvalue     - CSR write mask and data
//               dbg_halt          - freezes counting and pending set
//               tcfg_rd, cnt_rd   - TCFG and counter values for read-back
//               pending           - sticky interrupt pending
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_chan
    import csr_timer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        tcfg_we,
    input  logic        ticlr_we,
    input  logic [31:0] wmask,
    input  logic [31:0] wvalue,
    input  logic        dbg_halt,
    output logic [31:0] tcfg_rd,
    output logic [31:0] cnt_rd,
    output logic        pending
);

    tcfg_t       tcfg_q, tcfg_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;

    logic [31:0] w_merged;
    tcfg_t       w_tcfg_new;
    logic        w_load;
    logic        w_run;
    logic        w_zero;
    logic        w_set;
    logic        w_clr;

    always_comb begin
        w_merged = (wmask & wvalue) | (~wmask & tcfg_q);

        w_tcfg_new.en       = w_merged[TCFG_EN_BIT];
        w_tcfg_new.periodic = w_merged[TCFG_PERIODIC_BIT];
        w_tcfg_new.initval  = w_merged[TCFG_INITVAL_LSB +: TCFG_INITVAL_W];

        tcfg_d = tcfg_we ? w_tcfg_new : tcfg_q;

        w_zero = (cnt_q == 32'd0);
        w_load = tcfg_we & w_tcfg_new.en;
        // Counting uses the configuration in force before this edge
        w_run  = tcfg_q.en & ~dbg_halt & (cnt_q != CNT_IDLE);

        cnt_d = cnt_q;
        if (w_load) begin
            cnt_d = reload_value(w_tcfg_new);
        end else if (tcfg_we) begin
            // Write that leaves en=0: counter stays where it is
            cnt_d = cnt_q;
        end else if (w_run) begin
            if (w_zero) begin
                cnt_d = tcfg_q.periodic ? reload_value(tcfg_q) : CNT_IDLE;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end

        w_set = tcfg_q.en & ~dbg_halt & w_zero;
        w_clr = ticlr_we & wmask[TICLR_CLR_BIT] & wvalue[TICLR_CLR_BIT];
        // Set beats a simultaneous clear
        pending_d = w_set | (pending_q & ~w_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_q    <= '0;
            cnt_q     <= CNT_IDLE;
            pending_q <= 1'b0;
        end else begin
            tcfg_q    <= tcfg_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign tcfg_rd = tcfg_q;
    assign cnt_rd  = cnt_q;
    assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_bank
// Description : Bank of N_TIMER CSR timer channels with a shared free-running
//               stable counter. Decodes its own CSR window and returns read
//               data combinationally (zero on a miss).
// Ports       : clk, resetn           - clock, async active-low reset
//               csr_num/we/wmask/wvalue - CSR access
//               csr_hit, csr_rvalue   - window hit and read data
//               dbg_halt              - freezes all channel counters
//               timer_int             - per-channel pending interrupts
//               stable_counter        - free-running counter
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_bank
    import csr_timer_pkg::*;
#(
    parameter int          N_TIMER    = 2,
    parameter logic [13:0] TIMER_BASE = 14'h41,
    parameter int          CH_STRIDE  = 8,
    parameter int          SCNT_W     = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [13:0]        csr_num,
    input  logic               csr_we,
    input  logic [31:0]        csr_wmask,
    input  logic [31:0]        csr_wvalue,
    output logic               csr_hit,
    output logic [31:0]        csr_rvalue,
    input  logic               dbg_halt,
    output logic [N_TIMER-1:0] timer_int,
    output logic [SCNT_W-1:0]  stable_counter
);

    logic [31:0]        w_ch_rdata [N_TIMER];
    logic [N_TIMER-1:0] w_ch_hit;

    logic [SCNT_W-1:0]  scnt_q, scnt_d;

    for (genvar gi = 0; gi < N_TIMER; gi++) begin : g_chan
        localparam logic [13:0] c_base = TIMER_BASE + 14'(gi * CH_STRIDE);

        logic        w_sel_tcfg;
        logic        w_sel_tval;
        logic        w_sel_ticlr;
        logic [31:0] w_tcfg;
        logic [31:0] w_cnt;

        assign w_sel_tcfg  = (csr_num == c_base + REG_OFF_TCFG);
        assign w_sel_tval  = (csr_num == c_base + REG_OFF_TVAL);
        assign w_sel_ticlr = (csr_num == c_base + REG_OFF_TICLR);

        assign w_ch_hit[gi] = w_sel_tcfg | w_sel_tval | w_sel_ticlr;
        // TICLR reads as zero, so it contributes nothing to the data
        assign w_ch_rdata[gi] = ({32{w_sel_tcfg}} & w_tcfg)
                              | ({32{w_sel_tval}} & w_cnt);

        csr_timer_chan u_chan (
            .clk      (clk),
            .resetn   (resetn),
            .tcfg_we  (csr_we & w_sel_tcfg),
            .ticlr_we (csr_we & w_sel_ticlr),
            .wmask    (csr_wmask),
            .wvalue   (csr_wvalue),
            .dbg_halt (dbg_halt),
            .tcfg_rd  (w_tcfg),
            .cnt_rd   (w_cnt),
            .pending  (timer_int[gi])
        );
    end

    // At most one channel decodes a given number, so OR-ing is a clean mux
    always_comb begin
        csr_rvalue = '0;
        for (int k = 0; k < N_TIMER; k++) begin
            csr_rvalue = csr_rvalue | w_ch_rdata[k];
        end
        csr_hit = |w_ch_hit;
    end

    always_comb begin
        scnt_d = scnt_q + {{(SCNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign stable_counter = scnt_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_timer_bank
// Description : Self-checking bench for csr_timer_bank (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_csr_timer_bank;

    localparam int          N_TIMER    = 2;
    localparam logic [13:0] TIMER_BASE = 14'h41;
    localparam int          CH_STRIDE  = 8;
    localparam int          SCNT_W     = 64;

    localparam logic [13:0] A_TCFG0  = 14'h41;
    localparam logic [13:0] A_TVAL0  = 14'h42;
    localparam logic [13:0] A_TICLR0 = 14'h44;
    localparam logic [13:0] A_TCFG1  = 14'h49;
    localparam logic [13:0] A_TVAL1  = 14'h4A;
    localparam logic [13:0] A_TICLR1 = 14'h4C;
    localparam logic [31:0] IDLE     = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               resetn;
    logic [13:0]        csr_num;
    logic               csr_we;
    logic [31:0]        csr_wmask;
    logic [31:0]        csr_wvalue;
    logic               csr_hit;
    logic [31:0]        csr_rvalue;
    logic               dbg_halt;
    logic [N_TIMER-1:0] timer_int;
    logic [SCNT_W-1:0]  stable_counter;

    always #5 clk = ~clk;

    csr_timer_bank #(
        .N_TIMER    (N_TIMER),
        .TIMER_BASE (TIMER_BASE),
        .CH_STRIDE  (CH_STRIDE),
        .SCNT_W     (SCNT_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .csr_num        (csr_num),
        .csr_we         (csr_we),
        .csr_wmask      (csr_wmask),
        .csr_wvalue     (csr_wvalue),
        .csr_hit        (csr_hit),
        .csr_rvalue     (csr_rvalue),
        .dbg_halt       (dbg_halt),
        .timer_int      (timer_int),
        .stable_counter (stable_counter)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [13:0] addr;
        logic        exp_hit;
        logic [31:0] exp_val;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    typedef struct {
        logic [13:0] addr;
        logic        hit;
        logic [31:0] val;
    } dec_vec_t;

    dec_vec_t dec_tab[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input string name, input logic [13:0] addr,
                             input logic hit, input logic [31:0] val);
        rd_exp_t e;
        e.name    = name;
        e.addr    = addr;
        e.exp_hit = hit;
        e.exp_val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain_rd();
        rd_exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            csr_num = e.addr;
            #1;
            chk({e.name, " hit"}, 64'(csr_hit), 64'(e.exp_hit));
            chk({e.name, " rdata"}, 64'(csr_rvalue), 64'(e.exp_val));
        end
    endtask

    task automatic rd(input string name, input logic [13:0] addr,
                      input logic hit, input logic [31:0] val);
        expect_rd(name, addr, hit, val);
        drain_rd();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] mask, input logic [31:0] val);
        csr_num    = addr;
        csr_wmask  = mask;
        csr_wvalue = val;
        csr_we     = 1'b1;
        tick();
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]       exp_cnt;
        logic [SCNT_W-1:0] sc0;
        int                m_cnt;
        logic              m_int;
        logic              m_set;
        logic              clr;

        resetn     = 1'b0;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        dbg_halt   = 1'b0;

        dec_tab[0] = '{14'h41, 1'b1, 32'h0};
        dec_tab[1] = '{14'h42, 1'b1, IDLE};
        dec_tab[2] = '{14'h43, 1'b0, 32'h0};
        dec_tab[3] = '{14'h44, 1'b1, 32'h0};
        dec_tab[4] = '{14'h45, 1'b0, 32'h0};
        dec_tab[5] = '{14'h49, 1'b1, 32'h0};
        dec_tab[6] = '{14'h4A, 1'b1, IDLE};
        dec_tab[7] = '{14'h4C, 1'b1, 32'h0};
        dec_tab[8] = '{14'h40, 1'b0, 32'h0};
        dec_tab[9] = '{14'h51, 1'b0, 32'h0};

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst timer_int", 64'(timer_int), 64'd0);
        chk("rst scnt", 64'(stable_counter), 64'd0);
        resetn = 1'b1;
        chk("scnt at release", 64'(stable_counter), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("scnt step %0d", k), 64'(stable_counter), 64'(k));
        end

        // ---------------- decode table ----------------
        for (int k = 0; k < 10; k++) begin
            tick();
            rd($sformatf("decode 0x%0h", dec_tab[k].addr), dec_tab[k].addr,
               dec_tab[k].hit, dec_tab[k].val);
        end

        // ---------------- one-shot ch0 ----------------
        wr(A_TCFG0, 32'hFFFF_FFFF, 32'h0000_0005);
        rd("oneshot tcfg0", A_TCFG0, 1'b1, 32'h5);
        for (int k = 0; k <= 6; k++) begin
            exp_cnt = (k <= 4) ? 32'(4 - k) : IDLE;
            rd($sformatf("oneshot tval t+%0d", k), A_TVAL0, 1'b1, exp_cnt);
            chk($sformatf("oneshot int0 t+%0d", k), 64'(timer_int[0]), 64'(k >= 5));
            tick();
        end
        chk("oneshot int1 untouched", 64'(timer_int[1]), 64'd0);

        wr(A_TICLR0, 32'hFFFF_FFFF, 32'h0);
        chk("ticlr write 0 keeps int0", 64'(timer_int[0]), 64'd1);
        wr(A_TVAL0, 32'hFFFF_FFFF, 32'h123);
        rd("tval write ignored", A_TVAL0, 1'b1, IDLE);
        wr(A_TICLR0, 32'h1, 32'h1);
        chk("ticlr clears int0", 64'(timer_int[0]), 64'd0);

        // ---------------- periodic ch1 with clear and collision ----------------
        wr(A_TCFG1, 32'hFFFF_FFFF, 32'h0000_000B);
        m_cnt = 8;
        m_int = 1'b0;
        rd("periodic tval load", A_TVAL1, 1'b1, 32'd8);
        for (int k = 1; k <= 30; k++) begin
            // k==27 is the edge where cnt==0: clear collides with set
            clr = (k == 10) || (k == 27);
            if (clr) begin
                csr_num    = A_TICLR1;
                csr_wmask  = 32'h1;
                csr_wvalue = 32'h1;
                csr_we     = 1'b1;
            end
            tick();
            csr_we     = 1'b0;
            csr_wmask  = '0;
            csr_wvalue = '0;
            m_set = (m_cnt == 0);
            m_cnt = m_set ? 8 : m_cnt - 1;
            m_int = m_set | (m_int & ~clr);
            rd($sformatf("periodic tval k=%0d", k), A_TVAL1, 1'b1, 32'(m_cnt));
            chk($sformatf("periodic int1 k=%0d", k), 64'(timer_int[1]), 64'(m_int));
        end
        chk("collision int1 held", 64'(timer_int[1]), 64'd1);

        // ---------------- halt and masked write on ch0 ----------------
        wr(A_TCFG0, 32'hFFFF_FFFF, 32'h0000_0011);
        rd("halt tval load", A_TVAL0, 1'b1, 32'd16);
        tick();
        tick();
        rd("halt tval pre", A_TVAL0, 1'b1, 32'd14);
        sc0 = stable_counter;
        dbg_halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            rd($sformatf("halt tval hold %0d", k), A_TVAL0, 1'b1, 32'd14);
        end
        chk("halt scnt advance", 64'(stable_counter), 64'(sc0 + 64'd3));
        dbg_halt = 1'b0;
        tick();
        rd("halt tval resume", A_TVAL0, 1'b1, 32'd13);
        wr(A_TCFG0, 32'h0000_0001, 32'h0);
        rd("mask tcfg0", A_TCFG0, 1'b1, 32'h10);
        rd("mask tval frozen", A_TVAL0, 1'b1, 32'd13);
        tick();
        tick();
        rd("mask tval still frozen", A_TVAL0, 1'b1, 32'd13);

        // halt on the zero edge suppresses the pending set
        wr(A_TCFG0, 32'hFFFF_FFFF, 32'h0000_0005);
        repeat (4) tick();
        rd("halt zero tval", A_TVAL0, 1'b1, 32'd0);
        dbg_halt = 1'b1;
        tick();
        tick();
        rd("halt zero tval hold", A_TVAL0, 1'b1, 32'd0);
        chk("halt zero no set", 64'(timer_int[0]), 64'd0);
        dbg_halt = 1'b0;
        tick();
        rd("halt zero released tval", A_TVAL0, 1'b1, IDLE);
        chk("halt zero released int0", 64'(timer_int[0]), 64'd1);

        // ---------------- reset mid-count ----------------
        wr(A_TCFG0, 32'hFFFF_FFFF, 32'h0000_0011);
        tick();
        resetn = 1'b0;
        #1;
        rd("async rst tval0", A_TVAL0, 1'b1, IDLE);
        chk("async rst timer_int", 64'(timer_int), 64'd0);
        chk("async rst scnt", 64'(stable_counter), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        rd("post rst tval0", A_TVAL0, 1'b1, IDLE);
        rd("post rst tcfg0", A_TCFG0, 1'b1, 32'h0);
        rd("post rst tval1", A_TVAL1, 1'b1, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
